tag_caster_buf: RTL and testbench
=================================

Name: tag_caster_buf

Overview:
- Buffered, parametrised successor of the PE data caster. Sits between the shared broadcast bus and one PE.
- Accepts bus beats whose tag matches a runtime-programmable PE ID, or the broadcast tag. Queues matched beats for the PE.
- Queues PE results for the collection bus. Counts matched traffic.
- Replaces the combinational pass-through with decoupled valid/ready FIFOs on both directions.

Parameters:
- DATA_WIDTH, 16, width of operand and result words
- ID_WIDTH, 4, width of tag and PE ID
- IN_DEPTH, 4, bus-to-PE FIFO entries (power of 2, >=2)
- OUT_DEPTH, 4, PE-to-bus FIFO entries (power of 2, >=2)
- RESET_ID, 0, ID register value after reset
- BCAST_EN, 1, 1 = tag all-ones matches every caster
- CNT_WIDTH, 16, matched-beat counter width

Ports:
- clk, in, 1, clock
- rstn, in, 1, reset: synchronous, active-low
- cfg_id_we, in, 1, ID write strobe
- cfg_id, in, ID_WIDTH, new ID value
- cfg_err, out, 1, one-cycle pulse when an ID write is rejected
- flush, in, 1, synchronous clear of both FIFOs and the counter
- bus_valid, in, 1, bus beat valid
- bus_tag, in, ID_WIDTH, bus beat destination tag
- bus_data, in, DATA_WIDTH, bus beat payload
- bus_ready, out, 1, beat consumed by this caster
- pe_valid, out, 1, operand available to PE
- pe_data, out, DATA_WIDTH, operand (head of input FIFO)
- pe_ready, in, 1, PE consumes operand
- res_valid, in, 1, PE result valid
- res_data, in, DATA_WIDTH, PE result
- res_ready, out, 1, result FIFO can accept
- out_valid, out, 1, result available to collection bus
- out_data, out, DATA_WIDTH, result (head of output FIFO)
- out_tag, out, ID_WIDTH, current PE ID (source tag)
- out_ready, in, 1, collection bus consumes result
- match_cnt, out, CNT_WIDTH, saturating count of accepted matching beats
- busy, out, 1, either FIFO non-empty

Behaviour:
- Reset (rstn=0 at posedge):
  - FIFOs empty; pointers 0.
  - id_q=RESET_ID; match_cnt=0; cfg_err=0.
  - pe_valid, out_valid, busy = 0. res_ready=1.
  - bus_ready is combinational and follows the rules below.
- Reset mid-operation discards all queued data with no partial beats.
- Match: match = (bus_tag==id_q) | (BCAST_EN & bus_tag=={ID_WIDTH{1'b1}}).
- bus_ready = ~match | ~in_full.
  - Non-matching beats are consumed and discarded immediately.
  - Matching beats stall only when the input FIFO is full.
- Push to the input FIFO on bus_valid & bus_ready & match.
- Full check ignores a same-cycle pop: a full FIFO with pe_ready=1 still deasserts bus_ready that cycle.
- Input FIFO is first-word-fall-through:
  - pe_valid = ~in_empty; pe_data = head.
  - Pop on pe_valid & pe_ready.
  - Latency: beat accepted at edge N -> pe_valid=1 in the cycle after edge N.
- Output FIFO:
  - res_ready = ~out_full. Push on res_valid & res_ready.
  - out_valid = ~out_empty; pop on out_valid & out_ready. Same one-cycle latency.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance, wrap modulo depth.
- Push and pop together on an empty FIFO: pop is ignored because valid is low.
- match_cnt:
  - +1 per input push; holds at 2^CNT_WIDTH-1.
  - Cleared by flush or reset.
- ID write:
  - cfg_id_we & ~busy: id_q <= cfg_id next edge; the new ID is used for matching from the following cycle.
  - cfg_id_we & busy: write ignored, cfg_err=1 for one cycle.
- flush: empties both FIFOs and clears match_cnt at the edge; id_q is retained.
  - Push/pop in the flush cycle is discarded.
  - flush has priority over cfg_id_we; the ID write is then accepted because flush makes the block idle.
- out_tag = id_q at all times.

Decomposition:
- Package tag_caster_pkg:
  - BCAST_TAG(ID_WIDTH) function or constant.
  - tag_match function (tag, id, bcast_en).
  - clog2-based pointer width helper.
- Sub-module caster_fifo (WIDTH, DEPTH):
  - FWFT, sync active-low reset plus flush.
  - full/empty via extra pointer bit.
  - Instantiated twice, for the input and output FIFOs.

Test Plan:
- Reset then idle: out_valid=0, pe_valid=0, bus_ready=1, out_tag=0, match_cnt=0.
- id_q=3; beats tag 3/5/15/3 with data 0x11/0x22/0x33/0x44 and pe_ready=1 -> PE sees 0x11, 0x33, 0x44 in order; match_cnt=3; every beat gets bus_ready=1.
- id_q=3, pe_ready=0, 5 matching beats 0xA0..0xA4 -> bus_ready drops at the 5th; a non-matching tag-2 beat is still consumed. Then pe_ready=1 -> 0xA0..0xA3 are delivered, then 0xA4.
- Results 0x100..0x105 with out_ready=0 -> res_ready low after 4 pushes. Then out_ready=1 -> out_data 0x100.. in order with out_tag=3; wrap verified.
- cfg_id_we with cfg_id=7 while busy -> cfg_err pulse and id_q stays 3. After drain -> id_q=7 and tag-7 beats are accepted.
- flush with both FIFOs holding data, in the same cycle as bus_valid -> FIFOs empty next cycle, match_cnt=0, id_q kept; assert rstn=0 mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/tag_caster_pkg.sv
// rtl/tag_caster_pkg.sv - shared tag matching and pointer sizing helpers for the tag caster
package tag_caster_pkg;

  // Widest tag the helpers accept; callers zero-extend narrower tags.
  localparam int TAG_MAX_W = 32;

  // All-ones broadcast tag for a given tag width.
  function automatic logic [TAG_MAX_W-1:0] bcast_tag(input int w);
    return (TAG_MAX_W'(1) << w) - TAG_MAX_W'(1);
  endfunction

  // A beat belongs to this caster if it carries our ID, or the broadcast tag when enabled.
  function automatic logic tag_match(
    input logic [TAG_MAX_W-1:0] tag,
    input logic [TAG_MAX_W-1:0] id,
    input int                   w,
    input logic                 bcast_en
  );
    return (tag == id) || (bcast_en && (tag == bcast_tag(w)));
  endfunction

  // Address bits needed to index a FIFO of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/caster_fifo.sv
// rtl/caster_fifo.sv - first-word-fall-through FIFO with flush and extra-bit full/empty
module caster_fifo
  import tag_caster_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Pointers carry one wrap bit: equal means empty, only the wrap bit differing means full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop & ~w_empty;

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_pop_data = r_mem[r_rd_ptr[PW-1:0]];

  // Pointer update; flush drops any push or pop presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/tag_caster_buf.sv
// rtl/tag_caster_buf.sv - buffered tag-matching caster between broadcast bus and one PE
module tag_caster_buf
  import tag_caster_pkg::*;
#(
  parameter int                DATA_WIDTH = 16,
  parameter int                ID_WIDTH   = 4,
  parameter int                IN_DEPTH   = 4,
  parameter int                OUT_DEPTH  = 4,
  parameter logic [ID_WIDTH-1:0] RESET_ID = '0,
  parameter bit                BCAST_EN   = 1'b1,
  parameter int                CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_id_we,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  output logic                  cfg_err,
  input  logic                  flush,
  input  logic                  bus_valid,
  input  logic [ID_WIDTH-1:0]   bus_tag,
  input  logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_ready,
  output logic                  pe_valid,
  output logic [DATA_WIDTH-1:0] pe_data,
  input  logic                  pe_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_tag,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  match_cnt,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [ID_WIDTH-1:0]  r_id;
  logic [CNT_WIDTH-1:0] r_match_cnt;
  logic                 r_cfg_err;

  logic w_match;
  logic w_in_full;
  logic w_in_empty;
  logic w_out_full;
  logic w_out_empty;
  logic w_in_push;
  logic w_busy;

  assign w_match = tag_match(TAG_MAX_W'(bus_tag), TAG_MAX_W'(r_id), ID_WIDTH, BCAST_EN);

  // Non-matching beats are always swallowed; matching ones wait only on a full queue.
  assign bus_ready = ~w_match | ~w_in_full;
  assign w_in_push = bus_valid & bus_ready & w_match;
  assign w_busy    = ~w_in_empty | ~w_out_empty;

  caster_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_flush     (flush),
    .i_push      (w_in_push),
    .i_push_data (bus_data),
    .i_pop       (pe_ready),
    .o_pop_data  (pe_data),
    .o_full      (w_in_full),
    .o_empty     (w_in_empty)
  );

  caster_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_flush     (flush),
    .i_push      (res_valid),
    .i_push_data (res_data),
    .i_pop       (out_ready),
    .o_pop_data  (out_data),
    .o_full      (w_out_full),
    .o_empty     (w_out_empty)
  );

  assign pe_valid  = ~w_in_empty;
  assign res_ready = ~w_out_full;
  assign out_valid = ~w_out_empty;
  assign out_tag   = r_id;
  assign busy      = w_busy;
  assign match_cnt = r_match_cnt;
  assign cfg_err   = r_cfg_err;

  // ID register: writes land only when idle; flush makes the block idle so its write is taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_id      <= RESET_ID;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (cfg_id_we) begin
        if (flush || !w_busy) begin
          r_id <= cfg_id;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  // Saturating count of beats queued for the PE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_match_cnt <= '0;
    end else if (flush) begin
      r_match_cnt <= '0;
    end else if (w_in_push && (r_match_cnt != CNT_MAX)) begin
      r_match_cnt <= r_match_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_tag_caster_buf.sv
// tb/tb_tag_caster_buf.sv - directed self-checking bench for tag_caster_buf
module tb_tag_caster_buf;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_id_we;
  logic [3:0]  cfg_id;
  logic        cfg_err;
  logic        flush;
  logic        bus_valid;
  logic [3:0]  bus_tag;
  logic [15:0] bus_data;
  logic        bus_ready;
  logic        pe_valid;
  logic [15:0] pe_data;
  logic        pe_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_ready;
  logic [15:0] match_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  tag_caster_buf dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_id_we (cfg_id_we),
    .cfg_id    (cfg_id),
    .cfg_err   (cfg_err),
    .flush     (flush),
    .bus_valid (bus_valid),
    .bus_tag   (bus_tag),
    .bus_data  (bus_data),
    .bus_ready (bus_ready),
    .pe_valid  (pe_valid),
    .pe_data   (pe_data),
    .pe_ready  (pe_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .match_cnt (match_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_queues(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pe_valid"},  32'(pe_valid),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_bus_ready"}, 32'(bus_ready), 32'd1);
    chk({tag, "_res_ready"}, 32'(res_ready), 32'd1);
    chk({tag, "_out_tag"},   32'(out_tag),   32'd0);
    chk({tag, "_match_cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  tags  [4];
    logic [15:0] datas [4];
    tags  = '{4'd3, 4'd5, 4'd15, 4'd3};
    datas = '{16'h11, 16'h22, 16'h33, 16'h44};

    rstn = 1'b0; cfg_id_we = 1'b0; cfg_id = '0; flush = 1'b0;
    bus_valid = 1'b0; bus_tag = '0; bus_data = '0; pe_ready = 1'b0;
    res_valid = 1'b0; res_data = '0; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    rstn = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");

    // Program ID 3 while idle
    tick(); cfg_id_we = 1'b1; cfg_id = 4'd3;
    tick(); cfg_id_we = 1'b0;
    @(negedge clk);
    chk("id3_out_tag", 32'(out_tag), 32'd3);

    // Mixed tags with the PE always ready: only ID 3 and broadcast reach the PE
    pe_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_valid = 1'b1; bus_tag = tags[i]; bus_data = datas[i];
      @(negedge clk);
      chk("mix_bus_ready", 32'(bus_ready), 32'd1);
      if (pe_valid) got_q.push_back(pe_data);
    end
    tick(); bus_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pe_valid) got_q.push_back(pe_data);
    end
    exp_q = '{16'h11, 16'h33, 16'h44};
    cmp_queues("mix_pe");
    chk("mix_match_cnt", 32'(match_cnt), 32'd3);

    // Input FIFO fill with PE stalled
    pe_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus_valid = 1'b1; bus_tag = 4'd3; bus_data = 16'hA0 + 16'(i);
      @(negedge clk);
      chk("fill_bus_ready", 32'(bus_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    tick(); bus_tag = 4'd2; bus_data = 16'hEE;
    @(negedge clk);
    chk("nomatch_full_ready", 32'(bus_ready), 32'd1);
    got_q.delete();
    tick(); bus_tag = 4'd3; bus_data = 16'hA4; pe_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 32'(bus_ready), 32'd0);
    if (pe_valid) got_q.push_back(pe_data);
    tick();
    @(negedge clk);
    chk("after_pop_ready", 32'(bus_ready), 32'd1);
    if (pe_valid) got_q.push_back(pe_data);
    tick(); bus_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pe_valid) got_q.push_back(pe_data);
    end
    exp_q = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA4};
    cmp_queues("fill_pe");
    chk("fill_match_cnt", 32'(match_cnt), 32'd8);

    // Output FIFO fill with collection bus stalled
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      res_valid = 1'b1; res_data = 16'h100 + 16'(i);
      @(negedge clk);
      chk("res_ready", 32'(res_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    tick(); res_valid = 1'b0; cfg_id_we = 1'b1; cfg_id = 4'd7;
    tick(); cfg_id_we = 1'b0;
    @(negedge clk);
    chk("busy_cfg_err", 32'(cfg_err), 32'd1);
    chk("busy_id_kept", 32'(out_tag), 32'd3);
    @(negedge clk);
    chk("cfg_err_pulse", 32'(cfg_err), 32'd0);

    // Drain while pushing two more results so the pointers wrap
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      tick();
      out_ready = 1'b1;
      res_valid = (k == 1 || k == 2);
      res_data  = 16'h103 + 16'(k);
      @(negedge clk);
      if (out_valid) begin
        got_q.push_back(out_data);
        chk("drain_out_tag", 32'(out_tag), 32'd3);
      end
    end
    exp_q = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h104, 16'h105};
    cmp_queues("out");
    tick(); res_valid = 1'b0;

    // ID write accepted once idle, and the new ID matches
    cfg_id_we = 1'b1; cfg_id = 4'd7;
    tick(); cfg_id_we = 1'b0;
    @(negedge clk);
    chk("idle_id7", 32'(out_tag), 32'd7);
    chk("idle_cfg_err", 32'(cfg_err), 32'd0);
    tick(); bus_valid = 1'b1; bus_tag = 4'd7; bus_data = 16'h77;
    tick(); bus_valid = 1'b0;
    @(negedge clk);
    chk("id7_pe_valid", 32'(pe_valid), 32'd1);
    chk("id7_pe_data", 32'(pe_data), 32'h77);
    chk("id7_match_cnt", 32'(match_cnt), 32'd9);

    // Flush with both FIFOs holding data, plus a same-cycle ID write
    tick(); pe_ready = 1'b0; out_ready = 1'b0;
    bus_valid = 1'b1; bus_tag = 4'd7; bus_data = 16'h55; res_valid = 1'b1; res_data = 16'h200;
    tick(); bus_data = 16'h56; res_data = 16'h201;
    tick(); bus_data = 16'h57; res_data = 16'h202;
    flush = 1'b1; cfg_id_we = 1'b1; cfg_id = 4'd9;
    @(negedge clk);
    chk("pre_flush_busy", 32'(busy), 32'd1);
    chk("pre_flush_cnt", 32'(match_cnt), 32'd11);
    tick(); flush = 1'b0; cfg_id_we = 1'b0; bus_valid = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    chk("flush_pe_valid", 32'(pe_valid), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_match_cnt", 32'(match_cnt), 32'd0);
    chk("flush_id_write", 32'(out_tag), 32'd9);
    chk("flush_cfg_err", 32'(cfg_err), 32'd0);

    // Reset in the middle of traffic
    tick(); bus_valid = 1'b1; bus_tag = 4'd9; bus_data = 16'h66;
    res_valid = 1'b1; res_data = 16'h300;
    tick();
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    tick(); rstn = 1'b0;
    tick(); rstn = 1'b1; bus_valid = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
